// File: rtl/pbit_sweep_collector_pkg.sv
// Shared types and helpers for monitors of the one-hot p-bit update-enable bus.
package pbit_pkg;

  localparam int P_DEFAULT = 15;
  localparam int OH_W      = 64;

  typedef enum logic {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_zero;
    logic       is_onehot;
    logic [5:0] idx;
  } onehot_t;

  // Classifies a (zero-extended) bus value as idle, one-hot or multi-hot.
  function automatic onehot_t onehot_check(input logic [OH_W-1:0] vec);
    onehot_t     res;
    int unsigned cnt;
    res.is_zero = (vec == '0);
    res.idx     = 6'd0;
    cnt         = 32'd0;
    for (int i = 0; i < OH_W; i++) begin
      if (vec[i]) begin
        cnt     = cnt + 32'd1;
        res.idx = 6'(i);
      end
    end
    res.is_onehot = (cnt == 32'd1);
    return res;
  endfunction

endpackage

// File: rtl/pbit_sweep_collector_onehot_decoder.sv
// Combinational decode of one update-enable bus value into active/index/multi-hot.
module pbit_onehot_decoder
  import pbit_pkg::*;
#(
  parameter int P     = P_DEFAULT,
  parameter int IDX_W = $clog2(P + 1)
) (
  input  logic [P:0]       i_vec,
  output logic             o_active,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_multi
);

  onehot_t w_res;

  always_comb begin
    w_res    = onehot_check(OH_W'(i_vec));
    o_active = w_res.is_onehot;
    o_multi  = !w_res.is_zero && !w_res.is_onehot;
    o_idx    = IDX_W'(w_res.idx);
  end

endmodule

// File: rtl/pbit_sweep_collector.sv
// Samples each p-bit as its update window closes and hands off one snapshot per
// complete 0..P sweep, flagging multi-hot, out-of-order and dropped-snapshot events.
module pbit_sweep_collector
  import pbit_pkg::*;
#(
  parameter int P     = P_DEFAULT,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(P + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [P:0]       i_upd_seq,
  input  logic [P:0]       i_pbit_state,
  output logic [P:0]       o_snap_data,
  output logic             o_snap_valid,
  input  logic             i_snap_ready,
  output logic [CNT_W-1:0] o_sweep_count,
  output logic [IDX_W-1:0] o_upd_idx,
  output logic             o_upd_active,
  output logic             o_onehot_err,
  output logic             o_seq_err,
  output logic             o_overrun
);

  logic [P:0]       r_u_q;
  logic [P:0]       r_u_qq;
  logic             r_qq_active;
  logic [IDX_W-1:0] r_qq_idx;
  logic [IDX_W-1:0] r_last_idx;
  state_t           r_state;
  logic [IDX_W-1:0] r_expected;
  logic [P:0]       r_shadow;
  logic [P:0]       r_snap_data;
  logic             r_snap_valid;
  logic [CNT_W-1:0] r_sweep_count;
  logic             r_onehot_err;
  logic             r_seq_err;
  logic             r_overrun;

  logic             w_q_active;
  logic [IDX_W-1:0] w_q_idx;
  logic             w_q_multi;
  logic             w_close;
  logic [IDX_W-1:0] w_k;
  logic [P:0]       w_snap;

  pbit_onehot_decoder #(
    .P     (P),
    .IDX_W (IDX_W)
  ) u_dec (
    .i_vec    (r_u_q),
    .o_active (w_q_active),
    .o_idx    (w_q_idx),
    .o_multi  (w_q_multi)
  );

  // The u_qq decode is just the u_q decode delayed a cycle, so it is kept in r_qq_*.
  assign w_close = r_qq_active && (r_u_q != r_u_qq);
  assign w_k     = r_qq_idx;

  always_comb begin
    w_snap    = r_shadow;
    w_snap[P] = i_pbit_state[P];
    if (w_q_active) begin
      o_upd_idx = w_q_idx;
    end else begin
      o_upd_idx = r_last_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_u_q         <= '0;
      r_u_qq        <= '0;
      r_qq_active   <= 1'b0;
      r_qq_idx      <= '0;
      r_last_idx    <= '0;
      r_state       <= SYNC;
      r_expected    <= '0;
      r_shadow      <= '0;
      r_snap_data   <= '0;
      r_snap_valid  <= 1'b0;
      r_sweep_count <= '0;
      r_onehot_err  <= 1'b0;
      r_seq_err     <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_u_q       <= i_upd_seq;
      r_u_qq      <= r_u_q;
      r_qq_active <= w_q_active;
      r_qq_idx    <= w_q_idx;
      if (w_q_active) begin
        r_last_idx <= w_q_idx;
      end
      if (r_snap_valid && i_snap_ready) begin
        r_snap_valid <= 1'b0;
      end

      if (w_close) begin
        case (r_state)
          SYNC: begin
            if (w_k == '0) begin
              r_shadow   <= (P + 1)'(i_pbit_state[0]);
              r_expected <= IDX_W'(1);
              r_state    <= COLLECT;
            end
          end
          COLLECT: begin
            if (w_k != r_expected) begin
              r_seq_err  <= 1'b1;
              r_shadow   <= '0;
              r_expected <= '0;
              r_state    <= SYNC;
            end else if (w_k == IDX_W'(P)) begin
              r_shadow[w_k] <= i_pbit_state[w_k];
              r_sweep_count <= r_sweep_count + CNT_W'(1);
              r_expected    <= '0;
              // A held, unaccepted snapshot wins; the new one is dropped.
              if (!r_snap_valid || i_snap_ready) begin
                r_snap_data  <= w_snap;
                r_snap_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else if (w_k == '0) begin
              r_shadow   <= (P + 1)'(i_pbit_state[0]);
              r_expected <= IDX_W'(1);
            end else begin
              r_shadow[w_k] <= i_pbit_state[w_k];
              r_expected    <= w_k + IDX_W'(1);
            end
          end
          default: begin
            r_state <= SYNC;
          end
        endcase
      end

      // Multi-hot is handled after any close in the same cycle so the close still counts.
      if (w_q_multi) begin
        r_onehot_err <= 1'b1;
        r_state      <= SYNC;
        r_expected   <= '0;
      end
    end
  end

  assign o_snap_data   = r_snap_data;
  assign o_snap_valid  = r_snap_valid;
  assign o_sweep_count = r_sweep_count;
  assign o_upd_active  = w_q_active;
  assign o_onehot_err  = r_onehot_err;
  assign o_seq_err     = r_seq_err;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_pbit_sweep_collector.sv
// Directed scoreboard bench for pbit_sweep_collector with P=3.
module tb_pbit_sweep_collector;

  localparam int P     = 3;
  localparam int CNT_W = 16;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic [P:0]       i_upd_seq;
  logic [P:0]       i_pbit_state;
  logic [P:0]       o_snap_data;
  logic             o_snap_valid;
  logic             i_snap_ready;
  logic [CNT_W-1:0] o_sweep_count;
  logic [IDX_W-1:0] o_upd_idx;
  logic             o_upd_active;
  logic             o_onehot_err;
  logic             o_seq_err;
  logic             o_overrun;

  int         checks   = 0;
  int         failures = 0;
  logic [P:0] exp_q[$];
  logic [P:0] prev_seq = '0;
  logic       rdy      = 1'b1;

  always #5 clk = ~clk;

  pbit_sweep_collector #(
    .P     (P),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_upd_seq     (i_upd_seq),
    .i_pbit_state  (i_pbit_state),
    .o_snap_data   (o_snap_data),
    .o_snap_valid  (o_snap_valid),
    .i_snap_ready  (i_snap_ready),
    .o_sweep_count (o_sweep_count),
    .o_upd_idx     (o_upd_idx),
    .o_upd_active  (o_upd_active),
    .o_onehot_err  (o_onehot_err),
    .o_seq_err     (o_seq_err),
    .o_overrun     (o_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; also checks the 1-cycle-lagged decode of the previous value.
  task automatic drive(input logic [P:0] seq, input logic [P:0] st, input logic rst);
    logic             exp_act;
    logic [IDX_W-1:0] exp_idx;
    @(negedge clk);
    i_upd_seq    = seq;
    i_pbit_state = st;
    i_rst_n      = rst;
    i_snap_ready = rdy;
    #1;
    exp_act = $onehot(prev_seq);
    exp_idx = '0;
    for (int b = 0; b <= P; b++) begin
      if (prev_seq[b]) exp_idx = IDX_W'(b);
    end
    chk("upd_active", 32'(o_upd_active), 32'(exp_act));
    if (exp_act) chk("upd_idx", 32'(o_upd_idx), 32'(exp_idx));
    prev_seq = rst ? seq : '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, i_pbit_state, 1'b1);
  endtask

  // Slots 0..12 of the nominal pattern 1,1,0,2,2,0,4,4,0,8,8,0,0; rst low in [rlo,rhi].
  task automatic sweep_slots(input logic [P:0] data, input int first, input int last,
                             input int rlo, input int rhi, input bit tog);
    for (int s = first; s <= last; s++) begin
      logic [P:0] seq;
      logic [P:0] st;
      int         g;
      g   = s / 3;
      seq = (g <= P && (s % 3) < 2) ? (P + 1)'(1 << g) : '0;
      st  = data;
      if (tog) st[2] = (s == 9);
      drive(seq, st, (s >= rlo && s <= rhi) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic full_sweep(input logic [P:0] data, input bit tog, input bit keep);
    logic [P:0] e;
    e = data;
    if (tog) e[2] = 1'b1;
    if (keep) exp_q.push_back(e);
    sweep_slots(data, 0, 12, -1, -1, tog);
  endtask

  // Monitor: every handshake must match the oldest expected snapshot.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (o_snap_valid && i_snap_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL snap_unexpected: got data %b, expected no snapshot", o_snap_data);
        end else begin
          chk("snap_data", 32'(o_snap_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n      = 1'b0;
    i_upd_seq    = '0;
    i_pbit_state = '0;
    i_snap_ready = 1'b1;

    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);
    chk("rst_valid", 32'(o_snap_valid), 32'd0);
    chk("rst_data", 32'(o_snap_data), 32'd0);
    chk("rst_count", 32'(o_sweep_count), 32'd0);
    chk("rst_flags", {29'd0, o_onehot_err, o_seq_err, o_overrun}, 32'd0);
    chk("rst_idx", 32'(o_upd_idx), 32'd0);
    drive('0, '0, 1'b1);

    // Nominal sweep
    full_sweep(4'b1010, 1'b0, 1'b1);
    idle(1);
    chk("nom_count", 32'(o_sweep_count), 32'd1);
    chk("nom_flags", {29'd0, o_onehot_err, o_seq_err, o_overrun}, 32'd0);
    chk("nom_idx_hold", 32'(o_upd_idx), 32'd3);

    // Capture timing: bit 2 is high only in its close cycle
    full_sweep(4'b1001, 1'b1, 1'b1);
    idle(1);
    chk("cap_count", 32'(o_sweep_count), 32'd2);

    // Multi-hot then recovery
    drive(4'b0001, '0, 1'b1);
    drive(4'b0001, '0, 1'b1);
    drive(4'b0000, '0, 1'b1);
    drive(4'b0110, '0, 1'b1);
    drive(4'b0000, '0, 1'b1);
    full_sweep(4'b0111, 1'b0, 1'b1);
    idle(1);
    chk("mh_onehot_err", 32'(o_onehot_err), 32'd1);
    chk("mh_seq_err", 32'(o_seq_err), 32'd0);
    chk("mh_count", 32'(o_sweep_count), 32'd3);

    // Skipped index
    drive(4'b0001, '0, 1'b1);
    drive(4'b0001, '0, 1'b1);
    drive(4'b0000, '0, 1'b1);
    drive(4'b0100, '0, 1'b1);
    drive(4'b0100, '0, 1'b1);
    drive(4'b0000, '0, 1'b1);
    full_sweep(4'b1110, 1'b0, 1'b1);
    idle(1);
    chk("skip_seq_err", 32'(o_seq_err), 32'd1);
    chk("skip_count", 32'(o_sweep_count), 32'd4);

    // Backpressure and overrun
    rdy = 1'b0;
    full_sweep(4'b0011, 1'b0, 1'b1);
    full_sweep(4'b1100, 1'b0, 1'b0);
    idle(1);
    chk("bp_valid", 32'(o_snap_valid), 32'd1);
    chk("bp_data", 32'(o_snap_data), 32'b0011);
    chk("bp_overrun", 32'(o_overrun), 32'd1);
    chk("bp_count", 32'(o_sweep_count), 32'd6);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    idle(1);
    chk("bp_valid_clr", 32'(o_snap_valid), 32'd0);

    // Reset for one cycle after the index-1 close
    rdy = 1'b1;
    sweep_slots(4'b0101, 0, 7, 7, 7, 1'b0);
    idle(1);
    chk("mid_valid", 32'(o_snap_valid), 32'd0);
    chk("mid_data", 32'(o_snap_data), 32'd0);
    chk("mid_count", 32'(o_sweep_count), 32'd0);
    chk("mid_flags", {29'd0, o_onehot_err, o_seq_err, o_overrun}, 32'd0);
    chk("mid_idx", 32'(o_upd_idx), 32'd0);
    full_sweep(4'b0110, 1'b0, 1'b1);
    idle(1);
    chk("mid_count_after", 32'(o_sweep_count), 32'd1);

    // Partial start: reset released during index 2's window
    sweep_slots(4'b1111, 0, 12, 0, 6, 1'b0);
    idle(1);
    chk("part_count0", 32'(o_sweep_count), 32'd0);
    chk("part_valid0", 32'(o_snap_valid), 32'd0);
    full_sweep(4'b0101, 1'b0, 1'b1);
    full_sweep(4'b0110, 1'b0, 1'b1);
    idle(1);
    chk("part_count", 32'(o_sweep_count), 32'd2);
    chk("part_flags", {29'd0, o_onehot_err, o_seq_err, o_overrun}, 32'd0);

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
